fpga_host_nbf_sipo: RTL and testbench
=====================================

Name: fpga_host_nbf_sipo

Overview:
Receive-side deserializer of the FPGA host. Sits directly downstream of uart_rx and upstream of the NBF command consumer. It assembles UART bytes, least-significant byte first, into full NBF packets and presents them on a valid/ready interface. It double-buffers so one packet can be assembled while the previous one is stalled. It recovers from framing errors and inter-byte timeouts by discarding the partial packet.

Parameters:
nbf_opcode_width_p, 8, opcode field width (bits).
nbf_addr_width_p, 40, address field width (bits).
nbf_data_width_p, 64, data field width (bits).
timeout_clks_p, 20000, idle clocks allowed between bytes of one packet before the partial packet is discarded; must be >= 1.
Derived: nbf_width = opcode+addr+data = 112; must be a multiple of 8. nbf_bytes = nbf_width/8 = 14.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low
rx_v_i  in  1  one-cycle pulse: rx_i holds a received byte
rx_i  in  8  received byte
rx_error_i  in  1  one-cycle pulse: UART framing/parity error
nbf_o  out  nbf_width  assembled packet {data, addr, opcode}; byte 0 = bits [7:0]
nbf_v_o  out  1  nbf_o valid
nbf_ready_and_i  in  1  consumer accepts nbf_o when nbf_v_o & nbf_ready_and_i
frame_error_o  out  1  one-cycle pulse: partial packet discarded due to rx_error_i
timeout_o  out  1  one-cycle pulse: partial packet discarded due to timeout
overflow_o  out  1  one-cycle pulse: byte dropped because both buffers were full
byte_count_o  out  4  bytes held in the assembly buffer (debug)

Behaviour:
- Reset (reset==0, asynchronous): state=e_idle; byte count=0; timeout counter=0; assembly and output buffers cleared to 0; nbf_v_o=0; all error pulses=0.
- Assembly buffer: on each accepted byte, rx_i is written to byte lane [count] and count increments. No shift register.
- State e_idle (count==0):
  - rx_v_i → store byte 0, count=1, go to e_collect.
  - rx_error_i with no partial packet → ignored; no pulse.
- State e_collect:
  - rx_v_i → store byte, clear timeout counter.
  - If this is byte nbf_bytes-1 and the output slot is free (nbf_v_o==0, or nbf_v_o & nbf_ready_and_i this cycle) → next cycle nbf_o=assembled packet, nbf_v_o=1, count=0, go to e_idle.
  - If this is the last byte and the slot is not free → go to e_stall.
  - Latency: last rx_v_i to nbf_v_o rise is 1 cycle.
  - No rx_v_i → timeout counter +1. When it reaches timeout_clks_p: pulse timeout_o, count=0, go to e_idle.
  - rx_error_i → pulse frame_error_o, count=0, counter=0, go to e_idle. If rx_error_i and rx_v_i occur in the same cycle, the error wins and the byte is dropped.
- State e_stall (complete packet held):
  - Output slot frees → transfer to output buffer next cycle, go to e_idle.
  - rx_v_i while in e_stall, including the freeing cycle → byte dropped, overflow_o pulses.
  - rx_error_i in e_stall → ignored.
  - No timeout counting in e_stall.
- Output buffer: nbf_o is stable while nbf_v_o=1 and not accepted. nbf_v_o falls on acceptance unless a new packet transfers in the same cycle, in which case it stays high with the new data.
- Error pulses are registered, asserted exactly 1 cycle after the causing event, and are mutually exclusive per cycle.
- Reset asserted mid-packet discards all buffered state immediately.

Test Plan:
1. Send bytes 0x00..0x0D with nbf_ready_and_i=1 → one nbf_v_o pulse 1 cycle after the last byte; nbf_o=0x0D0C0B0A09080706050403020100; no error pulses.
2. Hold nbf_ready_and_i=0; send packet A (all 0x11), then packet B (all 0x22); release ready → A accepted, then B valid the next cycle. Send a 3rd packet's first byte while in e_stall → overflow_o pulses once; after the transfer, B is delivered intact.
3. Send 5 bytes, then idle timeout_clks_p cycles → timeout_o pulses; count=0. Then a full 14-byte packet → delivered correctly, no misalignment.
4. Send 7 bytes, then rx_error_i → frame_error_o pulse, count=0. A following full packet is delivered exactly.
5. Send 9 bytes, then assert reset for 2 cycles mid-stream → nbf_v_o=0, byte_count_o=0. Post-reset full packet is correct.
6. rx_error_i and rx_v_i asserted together at byte 3 → frame_error_o pulses, the byte is dropped, and no packet is produced.

Source files
------------

// File: rtl/fpga_host_nbf_sipo.sv
// Receive-side deserializer: gathers UART bytes (LSB first) into NBF packets,
// double-buffered behind a valid/ready output, with framing/timeout recovery.
module fpga_host_nbf_sipo #(
  parameter int unsigned nbf_opcode_width_p = 8,
  parameter int unsigned nbf_addr_width_p   = 40,
  parameter int unsigned nbf_data_width_p   = 64,
  parameter int unsigned timeout_clks_p     = 20000
) (
  input  logic                                                           clk,
  input  logic                                                           reset,
  input  logic                                                           rx_v_i,
  input  logic [7:0]                                                     rx_i,
  input  logic                                                           rx_error_i,
  output logic [nbf_opcode_width_p+nbf_addr_width_p+nbf_data_width_p-1:0] nbf_o,
  output logic                                                           nbf_v_o,
  input  logic                                                           nbf_ready_and_i,
  output logic                                                           frame_error_o,
  output logic                                                           timeout_o,
  output logic                                                           overflow_o,
  output logic [3:0]                                                     byte_count_o
);

  localparam int unsigned nbf_width_lp = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int unsigned nbf_bytes_lp = nbf_width_lp / 8;
  localparam int unsigned cnt_w_lp     = 4;
  localparam int unsigned tmo_w_lp     = $clog2(timeout_clks_p + 1);

  localparam logic [cnt_w_lp-1:0] last_byte_lp = cnt_w_lp'(nbf_bytes_lp - 1);
  localparam logic [tmo_w_lp-1:0] tmo_limit_lp = tmo_w_lp'(timeout_clks_p);

  localparam logic [1:0] e_idle    = 2'd0;
  localparam logic [1:0] e_collect = 2'd1;
  localparam logic [1:0] e_stall   = 2'd2;

  logic [1:0]                         state_q, state_d;
  logic [cnt_w_lp-1:0]                count_q, count_d;
  logic [tmo_w_lp-1:0]                tmo_q, tmo_d;
  logic [nbf_bytes_lp-1:0][7:0]       asm_q, asm_d;
  logic [nbf_width_lp-1:0]            out_q, out_d;
  logic                               out_v_q, out_v_d;
  logic                               frame_error_q, frame_error_d;
  logic                               timeout_q, timeout_d;
  logic                               overflow_q, overflow_d;
  logic                               slot_free;

  // Next-state, lane writes, output-slot handoff and error pulses.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    tmo_d         = tmo_q;
    asm_d         = asm_q;
    out_d         = out_q;
    out_v_d       = out_v_q;
    frame_error_d = 1'b0;
    timeout_d     = 1'b0;
    overflow_d    = 1'b0;
    slot_free     = !out_v_q || nbf_ready_and_i;

    if (out_v_q && nbf_ready_and_i) begin
      out_v_d = 1'b0;
    end

    case (state_q)
      e_idle: begin
        if (rx_v_i) begin
          asm_d[0] = rx_i;
          count_d  = cnt_w_lp'(1);
          tmo_d    = '0;
          state_d  = e_collect;
        end
      end

      e_collect: begin
        // An error in the same cycle as a byte wins; the byte is dropped.
        if (rx_error_i) begin
          frame_error_d = 1'b1;
          count_d       = '0;
          tmo_d         = '0;
          state_d       = e_idle;
        end else if (rx_v_i) begin
          asm_d[count_q] = rx_i;
          tmo_d          = '0;
          count_d        = count_q + cnt_w_lp'(1);
          if (count_q == last_byte_lp) begin
            if (slot_free) begin
              out_d   = asm_d;
              out_v_d = 1'b1;
              count_d = '0;
              state_d = e_idle;
            end else begin
              state_d = e_stall;
            end
          end
        end else begin
          tmo_d = tmo_q + tmo_w_lp'(1);
          if (tmo_d == tmo_limit_lp) begin
            timeout_d = 1'b1;
            count_d   = '0;
            tmo_d     = '0;
            state_d   = e_idle;
          end
        end
      end

      e_stall: begin
        if (rx_v_i) begin
          overflow_d = 1'b1;
        end
        if (slot_free) begin
          out_d   = asm_q;
          out_v_d = 1'b1;
          count_d = '0;
          state_d = e_idle;
        end
      end

      default: begin
        state_d = e_idle;
        count_d = '0;
        tmo_d   = '0;
      end
    endcase
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= e_idle;
      count_q       <= '0;
      tmo_q         <= '0;
      asm_q         <= '0;
      out_q         <= '0;
      out_v_q       <= 1'b0;
      frame_error_q <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      tmo_q         <= tmo_d;
      asm_q         <= asm_d;
      out_q         <= out_d;
      out_v_q       <= out_v_d;
      frame_error_q <= frame_error_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
    end
  end

  assign nbf_o         = out_q;
  assign nbf_v_o       = out_v_q;
  assign frame_error_o = frame_error_q;
  assign timeout_o     = timeout_q;
  assign overflow_o    = overflow_q;
  assign byte_count_o  = count_q;

endmodule

// File: tb/tb_fpga_host_nbf_sipo.sv
// Directed bench for fpga_host_nbf_sipo: assembly, double-buffer stall,
// overflow, timeout, framing error, and mid-packet reset recovery.
module tb_fpga_host_nbf_sipo;

  localparam int unsigned W    = 112;
  localparam int unsigned NB   = 14;
  localparam int unsigned TMO  = 25;

  logic         clk;
  logic         reset;
  logic         rx_v_i;
  logic [7:0]   rx_i;
  logic         rx_error_i;
  logic [W-1:0] nbf_o;
  logic         nbf_v_o;
  logic         nbf_ready_and_i;
  logic         frame_error_o;
  logic         timeout_o;
  logic         overflow_o;
  logic [3:0]   byte_count_o;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] acc_q[$];
  int fe_cnt = 0;
  int to_cnt = 0;
  int of_cnt = 0;

  fpga_host_nbf_sipo #(
    .nbf_opcode_width_p(8),
    .nbf_addr_width_p  (40),
    .nbf_data_width_p  (64),
    .timeout_clks_p    (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_v_i         (rx_v_i),
    .rx_i           (rx_i),
    .rx_error_i     (rx_error_i),
    .nbf_o          (nbf_o),
    .nbf_v_o        (nbf_v_o),
    .nbf_ready_and_i(nbf_ready_and_i),
    .frame_error_o  (frame_error_o),
    .timeout_o      (timeout_o),
    .overflow_o     (overflow_o),
    .byte_count_o   (byte_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (nbf_v_o && nbf_ready_and_i) acc_q.push_back(nbf_o);
    if (frame_error_o) fe_cnt = fe_cnt + 1;
    if (timeout_o)     to_cnt = to_cnt + 1;
    if (overflow_o)    of_cnt = of_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] ramp(input logic [7:0] base);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) p[i*8 +: 8] = base + 8'(i);
    return p;
  endfunction

  function automatic logic [W-1:0] fill(input logic [7:0] b);
    logic [W-1:0] p;
    for (int i = 0; i < NB; i++) p[i*8 +: 8] = b;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_v_i = 1'b1;
    rx_i   = b;
    step();
    rx_v_i = 1'b0;
    rx_i   = 8'h00;
  endtask

  task automatic send_ramp(input logic [7:0] base);
    for (int i = 0; i < NB; i++) send_byte(base + 8'(i));
  endtask

  task automatic send_fill(input logic [7:0] b);
    for (int i = 0; i < NB; i++) send_byte(b);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_v_i = 1'b0; rx_i = 8'h00; rx_error_i = 1'b0; nbf_ready_and_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({nbf_v_o, frame_error_o, timeout_o, overflow_o, byte_count_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b fe=%b to=%b of=%b cnt=%0d expected all 0",
               nbf_v_o, frame_error_o, timeout_o, overflow_o, byte_count_o);
    end
    checks++;
    if (nbf_o !== '0) begin
      errors++;
      $display("FAIL reset_nbf: got %h expected 0", nbf_o);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int acc0, fe0, to0, of0;
    acc0 = acc_q.size(); fe0 = fe_cnt; to0 = to_cnt; of0 = of_cnt;
    nbf_ready_and_i = 1'b1;
    send_ramp(8'h00);
    checks++;
    if (nbf_v_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got v=%b expected 1", nbf_v_o);
    end
    checks++;
    if (nbf_o !== 112'h0D0C0B0A09080706050403020100) begin
      errors++;
      $display("FAIL basic_data: got %h expected 0d0c0b0a09080706050403020100", nbf_o);
    end
    step();
    checks++;
    if (nbf_v_o !== 1'b0 || acc_q.size() != acc0 + 1) begin
      errors++;
      $display("FAIL basic_single: got v=%b accepted=%0d expected v=0 accepted=1",
               nbf_v_o, acc_q.size() - acc0);
    end
    checks++;
    if (fe_cnt != fe0 || to_cnt != to0 || of_cnt != of0) begin
      errors++;
      $display("FAIL basic_no_err: got fe=%0d to=%0d of=%0d expected 0 0 0",
               fe_cnt - fe0, to_cnt - to0, of_cnt - of0);
    end
  endtask

  task automatic test_back_to_back();
    int acc0, of0;
    acc0 = acc_q.size(); of0 = of_cnt;
    nbf_ready_and_i = 1'b0;
    send_fill(8'h11);
    send_fill(8'h22);
    checks++;
    if (nbf_v_o !== 1'b1 || nbf_o !== fill(8'h11) || byte_count_o !== 4'd14) begin
      errors++;
      $display("FAIL stall_hold: got v=%b nbf=%h cnt=%0d expected v=1 A cnt=14",
               nbf_v_o, nbf_o, byte_count_o);
    end
    send_byte(8'h33);
    checks++;
    if (overflow_o !== 1'b1 || byte_count_o !== 4'd14) begin
      errors++;
      $display("FAIL overflow_pulse: got of=%b cnt=%0d expected of=1 cnt=14", overflow_o, byte_count_o);
    end
    nbf_ready_and_i = 1'b1;
    step();
    checks++;
    if (nbf_v_o !== 1'b1 || nbf_o !== fill(8'h22) || overflow_o !== 1'b0 || byte_count_o !== 4'd0) begin
      errors++;
      $display("FAIL stall_transfer: got v=%b nbf=%h of=%b cnt=%0d expected v=1 B of=0 cnt=0",
               nbf_v_o, nbf_o, overflow_o, byte_count_o);
    end
    step();
    checks++;
    if (nbf_v_o !== 1'b0 || acc_q.size() != acc0 + 2 || of_cnt != of0 + 1) begin
      errors++;
      $display("FAIL stall_counts: got v=%b accepted=%0d of=%0d expected v=0 accepted=2 of=1",
               nbf_v_o, acc_q.size() - acc0, of_cnt - of0);
    end else begin
      checks++;
      if (acc_q[acc0] !== fill(8'h11) || acc_q[acc0+1] !== fill(8'h22)) begin
        errors++;
        $display("FAIL stall_order: got %h,%h expected A then B", acc_q[acc0], acc_q[acc0+1]);
      end
    end
  endtask

  task automatic test_timeout();
    nbf_ready_and_i = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    repeat (TMO - 1) step();
    checks++;
    if (timeout_o !== 1'b0 || byte_count_o !== 4'd5) begin
      errors++;
      $display("FAIL timeout_early: got to=%b cnt=%0d expected to=0 cnt=5", timeout_o, byte_count_o);
    end
    step();
    checks++;
    if (timeout_o !== 1'b1 || byte_count_o !== 4'd0) begin
      errors++;
      $display("FAIL timeout_pulse: got to=%b cnt=%0d expected to=1 cnt=0", timeout_o, byte_count_o);
    end
    step();
    send_ramp(8'h40);
    checks++;
    if (nbf_v_o !== 1'b1 || nbf_o !== ramp(8'h40) || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: got v=%b nbf=%h to=%b expected v=1 %h to=0",
               nbf_v_o, nbf_o, timeout_o, ramp(8'h40));
    end
    step();
  endtask

  task automatic test_frame_error();
    nbf_ready_and_i = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i));
    rx_error_i = 1'b1;
    step();
    rx_error_i = 1'b0;
    checks++;
    if (frame_error_o !== 1'b1 || byte_count_o !== 4'd0) begin
      errors++;
      $display("FAIL frame_pulse: got fe=%b cnt=%0d expected fe=1 cnt=0", frame_error_o, byte_count_o);
    end
    step();
    send_ramp(8'h80);
    checks++;
    if (nbf_v_o !== 1'b1 || nbf_o !== ramp(8'h80) || frame_error_o !== 1'b0) begin
      errors++;
      $display("FAIL frame_recover: got v=%b nbf=%h fe=%b expected v=1 %h fe=0",
               nbf_v_o, nbf_o, frame_error_o, ramp(8'h80));
    end
    step();
  endtask

  task automatic test_mid_reset();
    nbf_ready_and_i = 1'b0;
    send_ramp(8'h50);
    for (int i = 0; i < 9; i++) send_byte(8'hE0 + 8'(i));
    checks++;
    if (nbf_v_o !== 1'b1 || byte_count_o !== 4'd9) begin
      errors++;
      $display("FAIL pre_reset: got v=%b cnt=%0d expected v=1 cnt=9", nbf_v_o, byte_count_o);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (nbf_v_o !== 1'b0 || byte_count_o !== 4'd0 || nbf_o !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b cnt=%0d nbf=%h expected v=0 cnt=0 nbf=0",
               nbf_v_o, byte_count_o, nbf_o);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    nbf_ready_and_i = 1'b1;
    step();
    send_ramp(8'h60);
    checks++;
    if (nbf_v_o !== 1'b1 || nbf_o !== ramp(8'h60)) begin
      errors++;
      $display("FAIL post_reset: got v=%b nbf=%h expected v=1 %h", nbf_v_o, nbf_o, ramp(8'h60));
    end
    step();
  endtask

  task automatic test_error_with_byte();
    int acc0, fe0;
    nbf_ready_and_i = 1'b1;
    fe0 = fe_cnt;
    rx_error_i = 1'b1;
    step();
    rx_error_i = 1'b0;
    step();
    checks++;
    if (fe_cnt != fe0 || byte_count_o !== 4'd0) begin
      errors++;
      $display("FAIL idle_error_ignored: got fe=%0d cnt=%0d expected fe=0 cnt=0", fe_cnt - fe0, byte_count_o);
    end
    acc0 = acc_q.size();
    for (int i = 0; i < 3; i++) send_byte(8'h70 + 8'(i));
    rx_error_i = 1'b1;
    send_byte(8'h73);
    rx_error_i = 1'b0;
    checks++;
    if (frame_error_o !== 1'b1 || byte_count_o !== 4'd0) begin
      errors++;
      $display("FAIL err_wins: got fe=%b cnt=%0d expected fe=1 cnt=0", frame_error_o, byte_count_o);
    end
    repeat (4) step();
    checks++;
    if (nbf_v_o !== 1'b0 || acc_q.size() != acc0) begin
      errors++;
      $display("FAIL err_no_packet: got v=%b accepted=%0d expected v=0 accepted=0",
               nbf_v_o, acc_q.size() - acc0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_frame_error();
    test_mid_reset();
    test_error_with_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
